// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp memory game control path.
package chimp_pkg;

    localparam int CHIMP_BOARD_DIM = 8;
    localparam int CHIMP_NUM_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHOW,
        PLAY,
        WIN_PAUSE,
        FAIL_PAUSE,
        GAME_OVER
    } chimp_state_t;

endpackage

// File: rtl/chimp_delay_counter.sv
// Restartable delay counter: held at zero while iLoad is high, then counts up and
// saturates; oExpired marks the LIMIT-th cycle after iLoad drops.
module chimp_delay_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic iReset,
    input  logic iLoad,
    output logic oExpired
);

    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (iReset || iLoad) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign oExpired = (count == LAST);

endmodule

// File: rtl/chimp_round_ctrl.sv
// Chimp memory game round controller: sequences clear/load/show/play and judges clicks.
// Defining CHIMP_SHOW_TIMEOUT_EN makes SHOW fall through to PLAY after SHOW_CYCLES cycles.
module chimp_round_ctrl
    import chimp_pkg::*;
#(
    parameter int START_LEVEL  = 3,
    parameter int MAX_LEVEL    = 31,
    parameter int MAX_STRIKES  = 3,
    parameter int PAUSE_CYCLES = 50_000_000,
    parameter int SHOW_CYCLES  = 150_000_000
) (
    input  logic                   clk,
    input  logic                   iReset,
    input  logic                   iStart,
    input  logic                   iMouseClick,
    input  logic [CHIMP_NUM_W-1:0] iCellNum,
    input  logic                   iCellUsed,
    input  logic                   iDoneLoad,
    output logic                   oResetBoard,
    output logic                   oLoadEnable,
    output logic                   oShowEnable,
    output logic                   oClearCell,
    output logic [CHIMP_NUM_W-1:0] oLevel,
    output logic [CHIMP_NUM_W-1:0] oNumToChoose,
    output logic [1:0]             oStrikes,
    output logic                   oRoundWon,
    output logic                   oRoundLost,
    output logic                   oGameOver,
    output logic                   oWin
);

    localparam int                     BOARD_CELLS = CHIMP_BOARD_DIM * CHIMP_BOARD_DIM;
    localparam logic [CHIMP_NUM_W-1:0] START_LVL   = CHIMP_NUM_W'(START_LEVEL);
    localparam logic [CHIMP_NUM_W-1:0] MAX_LVL     = CHIMP_NUM_W'(MAX_LEVEL);
    localparam logic [1:0]             MAX_STR     = 2'(MAX_STRIKES);

    if (MAX_LEVEL > 31 || MAX_LEVEL >= BOARD_CELLS || START_LEVEL > MAX_LEVEL ||
        MAX_STRIKES < 1 || MAX_STRIKES > 3 || PAUSE_CYCLES < 1 || SHOW_CYCLES < 1) begin : gBadParams
        $error("chimp_round_ctrl: illegal parameter combination");
    end

    chimp_state_t state;
    chimp_state_t stateNext;

    logic [CHIMP_NUM_W-1:0] levelNext;
    logic [CHIMP_NUM_W-1:0] numNext;
    logic [1:0]             strikesNext;
    logic                   winNext;
    logic                   clearCellNext;
    logic                   loadFirst;
    logic                   inPause;
    logic                   pauseDone;
    logic                   showTimeout;
    logic                   clickValid;

    assign inPause    = (state == WIN_PAUSE) || (state == FAIL_PAUSE);
    assign clickValid = iMouseClick && iCellUsed;

    // Shared by both pause states; a pause never follows another directly, so holding it
    // in load outside the pauses restarts it on every pause entry.
    chimp_delay_counter #(
        .LIMIT(PAUSE_CYCLES)
    ) uPauseCounter (
        .clk     (clk),
        .iReset  (iReset),
        .iLoad   (!inPause),
        .oExpired(pauseDone)
    );

`ifdef CHIMP_SHOW_TIMEOUT_EN
    chimp_delay_counter #(
        .LIMIT(SHOW_CYCLES)
    ) uShowCounter (
        .clk     (clk),
        .iReset  (iReset),
        .iLoad   (state != SHOW),
        .oExpired(showTimeout)
    );
`else
    assign showTimeout = 1'b0;
`endif

    always_comb begin
        stateNext     = state;
        levelNext     = oLevel;
        numNext       = oNumToChoose;
        strikesNext   = oStrikes;
        winNext       = oWin;
        clearCellNext = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) stateNext = CLEAR;
            end
            CLEAR: begin
                numNext   = '0;
                stateNext = LOAD;
            end
            LOAD: begin
                // The datapath's done flag is still stale during the first LOAD cycle.
                if (iDoneLoad && !loadFirst) stateNext = SHOW;
            end
            SHOW, PLAY: begin
                if (clickValid) begin
                    if (iCellNum == oNumToChoose) begin
                        clearCellNext = 1'b1;
                        numNext       = oNumToChoose + CHIMP_NUM_W'(1);
                        stateNext     = (oNumToChoose == oLevel) ? WIN_PAUSE : PLAY;
                    end else begin
                        if (oStrikes != MAX_STR) strikesNext = oStrikes + 2'd1;
                        stateNext = FAIL_PAUSE;
                    end
                end else if ((state == SHOW) && showTimeout) begin
                    stateNext = PLAY;
                end
            end
            WIN_PAUSE: begin
                if (pauseDone) begin
                    if (oLevel == MAX_LVL) begin
                        winNext   = 1'b1;
                        stateNext = GAME_OVER;
                    end else begin
                        levelNext = oLevel + CHIMP_NUM_W'(1);
                        stateNext = CLEAR;
                    end
                end
            end
            FAIL_PAUSE: begin
                if (pauseDone) stateNext = (oStrikes == MAX_STR) ? GAME_OVER : CLEAR;
            end
            GAME_OVER: begin
                if (iStart) begin
                    levelNext   = START_LVL;
                    strikesNext = '0;
                    winNext     = 1'b0;
                    stateNext   = CLEAR;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Flags are registered from the next state so every output is a clean flop.
    always_ff @(posedge clk) begin
        if (iReset) begin
            state        <= IDLE;
            oLevel       <= START_LVL;
            oNumToChoose <= '0;
            oStrikes     <= '0;
            oWin         <= 1'b0;
            oClearCell   <= 1'b0;
            oResetBoard  <= 1'b0;
            oLoadEnable  <= 1'b0;
            oShowEnable  <= 1'b0;
            oRoundWon    <= 1'b0;
            oRoundLost   <= 1'b0;
            oGameOver    <= 1'b0;
            loadFirst    <= 1'b0;
        end else begin
            state        <= stateNext;
            oLevel       <= levelNext;
            oNumToChoose <= numNext;
            oStrikes     <= strikesNext;
            oWin         <= winNext;
            oClearCell   <= clearCellNext;
            oResetBoard  <= (stateNext == CLEAR);
            oLoadEnable  <= (stateNext == LOAD);
            oShowEnable  <= (stateNext == SHOW);
            oRoundWon    <= (stateNext == WIN_PAUSE);
            oRoundLost   <= (stateNext == FAIL_PAUSE);
            oGameOver    <= (stateNext == GAME_OVER);
            loadFirst    <= (state == CLEAR);
        end
    end

endmodule

// File: tb/tb_chimp_round_ctrl.sv
// Randomized scoreboard bench for chimp_round_ctrl; a game-level model predicts the
// sequence of observable events (board clears, reveals, cell clears, round results).
module tb_chimp_round_ctrl;

    localparam int START_LEVEL  = 3;
    localparam int MAX_LEVEL    = 5;
    localparam int MAX_STRIKES  = 3;
    localparam int PAUSE_CYCLES = 4;
    localparam int SHOW_CYCLES  = 10;
    localparam int WAIT_BUDGET  = 200;

    localparam int W_LOAD = 0;
    localparam int W_SHOW = 1;
    localparam int W_WON  = 2;
    localparam int W_LOST = 3;

    logic       clk         = 1'b0;
    logic       iReset      = 1'b1;
    logic       iStart      = 1'b0;
    logic       iMouseClick = 1'b0;
    logic [4:0] iCellNum    = '0;
    logic       iCellUsed   = 1'b0;
    logic       iDoneLoad   = 1'b0;
    logic       oResetBoard, oLoadEnable, oShowEnable, oClearCell;
    logic [4:0] oLevel, oNumToChoose;
    logic [1:0] oStrikes;
    logic       oRoundWon, oRoundLost, oGameOver, oWin;

    chimp_round_ctrl #(
        .START_LEVEL (START_LEVEL),
        .MAX_LEVEL   (MAX_LEVEL),
        .MAX_STRIKES (MAX_STRIKES),
        .PAUSE_CYCLES(PAUSE_CYCLES),
        .SHOW_CYCLES (SHOW_CYCLES)
    ) dut (
        .clk         (clk),
        .iReset      (iReset),
        .iStart      (iStart),
        .iMouseClick (iMouseClick),
        .iCellNum    (iCellNum),
        .iCellUsed   (iCellUsed),
        .iDoneLoad   (iDoneLoad),
        .oResetBoard (oResetBoard),
        .oLoadEnable (oLoadEnable),
        .oShowEnable (oShowEnable),
        .oClearCell  (oClearCell),
        .oLevel      (oLevel),
        .oNumToChoose(oNumToChoose),
        .oStrikes    (oStrikes),
        .oRoundWon   (oRoundWon),
        .oRoundLost  (oRoundLost),
        .oGameOver   (oGameOver),
        .oWin        (oWin)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_BOARD, EV_SHOW, EV_CELL, EV_WON, EV_LOST, EV_OVER} evKind_t;
    typedef struct packed {
        evKind_t kind;
        int      level;
        int      num;
        int      strikes;
        int      len;
        int      flag;
    } event_t;

    event_t expQ[$];
    int     testsRun    = 0;
    int     testsFailed = 0;
    int     modelLevel;
    int     modelStrikes;
    bit     modelWin;
    bit     gameEnded;

    function automatic event_t mkEvent(evKind_t kind, int level, int num, int strikes, int len, int flag);
        event_t e;
        e.kind    = kind;
        e.level   = level;
        e.num     = num;
        e.strikes = strikes;
        e.len     = len;
        e.flag    = flag;
        return e;
    endfunction

    function automatic string fmtEvent(event_t e);
        return $sformatf("%s level=%0d num=%0d strikes=%0d len=%0d flag=%0d",
                         e.kind.name(), e.level, e.num, e.strikes, e.len, e.flag);
    endfunction

    task automatic scoreEvent(input event_t got);
        event_t want;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected event: got %s, required no event", fmtEvent(got));
        end else begin
            want = expQ.pop_front();
            if (got != want) begin
                testsFailed++;
                $display("[TB] FAIL event %s: got %s, required %s",
                         want.kind.name(), fmtEvent(got), fmtEvent(want));
            end
        end
    endtask

    // Monitor: turns output edges into events, measuring pulse and phase lengths.
    logic pRb = 1'b0, pLe = 1'b0, pSe = 1'b0, pRw = 1'b0, pRl = 1'b0, pGo = 1'b0;
    int   rbLen = 0, leLen = 0, rwLen = 0, rlLen = 0;

    always @(negedge clk) begin
        if (pRb && !oResetBoard)
            scoreEvent(mkEvent(EV_BOARD, oLevel, oNumToChoose, oStrikes, rbLen, 0));
        if (!pSe && oShowEnable)
            scoreEvent(mkEvent(EV_SHOW, oLevel, oNumToChoose, oStrikes, leLen, 0));
        if (oClearCell)
            scoreEvent(mkEvent(EV_CELL, oLevel, oNumToChoose, oStrikes, 0, int'(oShowEnable)));
        if (pRw && !oRoundWon)
            scoreEvent(mkEvent(EV_WON, oLevel, 0, oStrikes, rwLen, 0));
        if (pRl && !oRoundLost)
            scoreEvent(mkEvent(EV_LOST, oLevel, 0, oStrikes, rlLen, 0));
        if (!pGo && oGameOver)
            scoreEvent(mkEvent(EV_OVER, oLevel, 0, oStrikes, 0, int'(oWin)));
        if (oResetBoard) rbLen <= pRb ? rbLen + 1 : 1;
        if (oLoadEnable) leLen <= pLe ? leLen + 1 : 1;
        if (oRoundWon)   rwLen <= pRw ? rwLen + 1 : 1;
        if (oRoundLost)  rlLen <= pRl ? rlLen + 1 : 1;
        pRb <= oResetBoard;
        pLe <= oLoadEnable;
        pSe <= oShowEnable;
        pRw <= oRoundWon;
        pRl <= oRoundLost;
        pGo <= oGameOver;
    end

    function automatic logic outSel(input int which);
        case (which)
            W_LOAD:  return oLoadEnable;
            W_SHOW:  return oShowEnable;
            W_WON:   return oRoundWon;
            default: return oRoundLost;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        testsRun++;
        if (actual != required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic waitFor(input int which, input logic level, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            if (outSel(which) == level) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL wait %s: not %0b after %0d cycles, required %0b", name, level, WAIT_BUDGET, level);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] value, input logic used);
        iMouseClick = 1'b1;
        iCellNum    = value;
        iCellUsed   = used;
        @(negedge clk);
        iMouseClick = 1'b0;
        iCellUsed   = 1'($urandom_range(0, 1));
        iCellNum    = 5'($urandom_range(0, 31));
    endtask

    task automatic pulseStart();
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // Done is raised k cycles into LOAD; the first LOAD cycle never counts.
    task automatic doLoad();
        int k;
        waitFor(W_LOAD, 1'b1, "oLoadEnable");
        k = $urandom_range(0, 3);
        expQ.push_back(mkEvent(EV_SHOW, modelLevel, 0, modelStrikes, (k < 1) ? 2 : k + 1, 0));
        repeat (k) @(negedge clk);
        iDoneLoad = 1'b1;
        waitFor(W_SHOW, 1'b1, "oShowEnable");
        iDoneLoad = 1'b0;
    endtask

    task automatic recordWin();
        bool_win: begin
            if (modelLevel == MAX_LEVEL) begin
                expQ.push_back(mkEvent(EV_WON, modelLevel, 0, modelStrikes, PAUSE_CYCLES, 0));
                expQ.push_back(mkEvent(EV_OVER, modelLevel, 0, modelStrikes, 0, 1));
                modelWin  = 1'b1;
                gameEnded = 1'b1;
            end else begin
                modelLevel++;
                expQ.push_back(mkEvent(EV_WON, modelLevel, 0, modelStrikes, PAUSE_CYCLES, 0));
                expQ.push_back(mkEvent(EV_BOARD, modelLevel, 0, modelStrikes, 1, 0));
            end
        end
    endtask

    task automatic recordLoss();
        if (modelStrikes < MAX_STRIKES) modelStrikes++;
        expQ.push_back(mkEvent(EV_LOST, modelLevel, 0, modelStrikes, PAUSE_CYCLES, 0));
        if (modelStrikes == MAX_STRIKES) begin
            expQ.push_back(mkEvent(EV_OVER, modelLevel, 0, modelStrikes, 0, 0));
            modelWin  = 1'b0;
            gameEnded = 1'b1;
        end else begin
            expQ.push_back(mkEvent(EV_BOARD, modelLevel, 0, modelStrikes, 1, 0));
        end
    endtask

    // Clicks numbers j0..level in order, or a wrong number at a random step.
    task automatic playRound(input int j0, input int winPct);
        bit willWin;
        int failAt;
        int v;
        willWin = ($urandom_range(0, 99) < winPct);
        failAt  = willWin ? -1 : int'($urandom_range(j0, modelLevel));
        for (int j = j0; j <= MAX_LEVEL; j++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(5'($urandom_range(0, 31)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (j == failAt) begin
                v = (j + int'($urandom_range(1, 31))) % 32;
                recordLoss();
                applyStimulus(5'(v), 1'b1);
                break;
            end
            expQ.push_back(mkEvent(EV_CELL, modelLevel, (j + 1) % 32, modelStrikes, 0, 0));
            if (j == modelLevel) begin
                recordWin();
                applyStimulus(5'(j), 1'b1);
                break;
            end
            applyStimulus(5'(j), 1'b1);
        end
        pulseStart();
        applyStimulus(5'($urandom_range(0, 31)), 1'b1);
        waitFor(willWin ? W_WON : W_LOST, 1'b0, "pause end");
    endtask

    initial begin
        int gameIdx;
        int rounds;
        int winPct[3] = '{90, 50, 60};
        modelLevel   = START_LEVEL;
        modelStrikes = 0;
        modelWin     = 1'b0;
        gameEnded    = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset oLevel", oLevel, START_LEVEL);
        checkOutput("reset oStrikes", oStrikes, 0);
        checkOutput("reset oNumToChoose", oNumToChoose, 0);
        checkOutput("reset oResetBoard", oResetBoard, 0);
        checkOutput("reset oLoadEnable", oLoadEnable, 0);
        checkOutput("reset oShowEnable", oShowEnable, 0);
        checkOutput("reset oClearCell", oClearCell, 0);
        checkOutput("reset oRoundWon", oRoundWon, 0);
        checkOutput("reset oRoundLost", oRoundLost, 0);
        checkOutput("reset oGameOver", oGameOver, 0);
        checkOutput("reset oWin", oWin, 0);
        iReset = 1'b0;

        iDoneLoad = 1'b1;
        applyStimulus(5'd0, 1'b1);
        iDoneLoad = 1'b0;
        @(negedge clk);
        checkOutput("idle ignores click", oShowEnable, 0);
        checkOutput("idle stays idle", oLoadEnable, 0);

        expQ.push_back(mkEvent(EV_BOARD, START_LEVEL, 0, 0, 1, 0));
        pulseStart();
        checkOutput("start oResetBoard", oResetBoard, 1);
        doLoad();
        checkOutput("show oLevel", oLevel, START_LEVEL);
        checkOutput("show oNumToChoose", oNumToChoose, 0);
`ifdef CHIMP_SHOW_TIMEOUT_EN
        repeat (SHOW_CYCLES - 1) @(negedge clk);
        checkOutput("show held until timeout", oShowEnable, 1);
        @(negedge clk);
        checkOutput("timeout oShowEnable", oShowEnable, 0);
        checkOutput("timeout oNumToChoose", oNumToChoose, 0);
`else
        repeat (SHOW_CYCLES + 2) @(negedge clk);
        checkOutput("show held without click", oShowEnable, 1);
`endif
        expQ.push_back(mkEvent(EV_CELL, START_LEVEL, 1, 0, 0, 0));
        applyStimulus(5'd0, 1'b1);
        checkOutput("first click oShowEnable", oShowEnable, 0);
        applyStimulus(5'($urandom_range(0, 31)), 1'b0);
        checkOutput("unused click oNumToChoose", oNumToChoose, 1);
        checkOutput("unused click oRoundLost", oRoundLost, 0);
        playRound(1, 25);

        gameIdx = 0;
        rounds  = 0;
        while (rounds < 60) begin
            rounds++;
            if (gameEnded) begin
                checkOutput("game over oGameOver", oGameOver, 1);
                checkOutput("game over oWin", oWin, int'(modelWin));
                checkOutput("game over oLevel", oLevel, modelLevel);
                checkOutput("game over oStrikes", oStrikes, modelStrikes);
                applyStimulus(5'($urandom_range(0, 31)), 1'b1);
                gameIdx++;
                if (gameIdx == 3) break;
                modelLevel   = START_LEVEL;
                modelStrikes = 0;
                modelWin     = 1'b0;
                gameEnded    = 1'b0;
                expQ.push_back(mkEvent(EV_BOARD, START_LEVEL, 0, 0, 1, 0));
                pulseStart();
                checkOutput("restart oLevel", oLevel, START_LEVEL);
                checkOutput("restart oStrikes", oStrikes, 0);
                checkOutput("restart oWin", oWin, 0);
                checkOutput("restart oGameOver", oGameOver, 0);
            end
            doLoad();
            playRound(0, winPct[gameIdx]);
        end
        checkOutput("games completed", gameIdx, 3);

        expQ.push_back(mkEvent(EV_BOARD, START_LEVEL, 0, 0, 1, 0));
        pulseStart();
        waitFor(W_LOAD, 1'b1, "oLoadEnable");
        iReset    = 1'b1;
        iDoneLoad = 1'b1;
        @(negedge clk);
        iReset = 1'b0;
        checkOutput("load reset oLoadEnable", oLoadEnable, 0);
        checkOutput("load reset oResetBoard", oResetBoard, 0);
        checkOutput("load reset oLevel", oLevel, START_LEVEL);
        checkOutput("load reset oStrikes", oStrikes, 0);
        checkOutput("load reset oNumToChoose", oNumToChoose, 0);
        checkOutput("load reset oGameOver", oGameOver, 0);
        repeat (2) @(negedge clk);
        checkOutput("idle after reset oShowEnable", oShowEnable, 0);
        iDoneLoad = 1'b0;

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500_000;
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL watchdog: still running at %0t, required completion", $time);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
